// File: rtl/aq_gemac_pkg.sv
// rtl/aq_gemac_pkg.sv - shared types and constants for the aq_gemac TX path
// Holds the TX arbiter FSM encoding, MAC TX buffer port widths and the default
// free-space threshold used before a frame is granted.
package aq_gemac_pkg;

    localparam int TX_DATA_W  = 32;
    localparam int TX_SPACE_W = 10;

    localparam logic [TX_SPACE_W-1:0] DEF_MIN_SPACE = 10'd400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/aq_gemac_tx_arb_pick.sv
// rtl/aq_gemac_tx_arb_pick.sv - combinational winner select for the TX arbiter
// Ports:
//   req    in  2  pending requests, bit n = requester n
//   last   in  1  index served most recently (round-robin pointer)
//   gnt_oh out 2  one-hot winner, 0 when nobody requests
module aq_gemac_tx_arb_pick
    import aq_gemac_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_oh
);

    always_comb begin
        gnt_oh = 2'b00;
        if (PRIO_MODE != 0) begin
            if (req[0])      gnt_oh = 2'b01;
            else if (req[1]) gnt_oh = 2'b10;
        end else begin
            // The requester that was not served last gets first look.
            if (last) begin
                if (req[0])      gnt_oh = 2'b01;
                else if (req[1]) gnt_oh = 2'b10;
            end else begin
                if (req[1])      gnt_oh = 2'b10;
                else if (req[0]) gnt_oh = 2'b01;
            end
        end
    end

endmodule

// File: rtl/aq_gemac_tx_arb.sv
// rtl/aq_gemac_tx_arb.sv - frame-atomic arbiter for the MAC TX buffer write port
// Shares the MAC TX buffer between requester 0 (L3 controller) and requester 1
// (UDP controller). One frame per grant, strobes registered once toward the MAC.
// Ports:
//   RST_N, sys_clk                       async active-low reset, clock
//   REQn / GNTn                          frame request / grant per requester
//   WEn, STARTn, ENDn, DATAn             requester write strobes and data
//   READYn, FULLn, SPACEn                MAC status, forwarded to the grantee only
//   TX_WE, TX_START, TX_END, TX_DATA     registered write port to the MAC buffer
//   TX_READY, TX_FULL, TX_SPACE          MAC buffer status
//   FRAME_CNTn, TIMEOUT_CNT, ARB_BUSY    statistics and status
module aq_gemac_tx_arb
    import aq_gemac_pkg::*;
#(
    parameter int unsigned            PRIO_MODE     = 0,
    parameter logic [TX_SPACE_W-1:0]  MIN_SPACE     = DEF_MIN_SPACE,
    parameter logic [15:0]            START_TIMEOUT = 16'd1024
) (
    input  logic                   RST_N,
    input  logic                   sys_clk,
    input  logic                   REQ0,
    input  logic                   REQ1,
    output logic                   GNT0,
    output logic                   GNT1,
    input  logic                   WE0,
    input  logic                   START0,
    input  logic                   END0,
    input  logic [TX_DATA_W-1:0]   DATA0,
    input  logic                   WE1,
    input  logic                   START1,
    input  logic                   END1,
    input  logic [TX_DATA_W-1:0]   DATA1,
    output logic                   READY0,
    output logic                   READY1,
    output logic                   FULL0,
    output logic                   FULL1,
    output logic [TX_SPACE_W-1:0]  SPACE0,
    output logic [TX_SPACE_W-1:0]  SPACE1,
    output logic                   TX_WE,
    output logic                   TX_START,
    output logic                   TX_END,
    output logic [TX_DATA_W-1:0]   TX_DATA,
    input  logic                   TX_READY,
    input  logic                   TX_FULL,
    input  logic [TX_SPACE_W-1:0]  TX_SPACE,
    output logic [15:0]            FRAME_CNT0,
    output logic [15:0]            FRAME_CNT1,
    output logic [7:0]             TIMEOUT_CNT,
    output logic                   ARB_BUSY
);

    arb_state_t             state_q, state_d;
    logic [1:0]             gnt_q, gnt_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [15:0]            wd_q, wd_d;
    logic                   tx_we_q, tx_we_d;
    logic                   tx_start_q, tx_start_d;
    logic                   tx_end_q, tx_end_d;
    logic [TX_DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [15:0]            fc0_q, fc0_d;
    logic [15:0]            fc1_q, fc1_d;
    logic [7:0]             tc_q, tc_d;

    logic [1:0]             pick_oh;
    logic                   eligible;
    logic                   sel_req, sel_we, sel_start, sel_end;
    logic [TX_DATA_W-1:0]   sel_data;

    aq_gemac_tx_arb_pick #(
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .req    ({REQ1, REQ0}),
        .last   (last_q),
        .gnt_oh (pick_oh)
    );

    assign eligible = (REQ0 | REQ1) && TX_READY && !TX_FULL && (TX_SPACE >= MIN_SPACE);

    // owner_q is only meaningful while a grant is outstanding (GRANT/XFER);
    // the FSM never looks at the selected strobes in IDLE or RELEASE.
    assign sel_req   = owner_q ? REQ1   : REQ0;
    assign sel_we    = owner_q ? WE1    : WE0;
    assign sel_start = owner_q ? START1 : START0;
    assign sel_end   = owner_q ? END1   : END0;
    assign sel_data  = owner_q ? DATA1  : DATA0;

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 2'b00;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            wd_q       <= 16'd0;
            tx_we_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_end_q   <= 1'b0;
            tx_data_q  <= '0;
            fc0_q      <= 16'd0;
            fc1_q      <= 16'd0;
            tc_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            tx_we_q    <= tx_we_d;
            tx_start_q <= tx_start_d;
            tx_end_q   <= tx_end_d;
            tx_data_q  <= tx_data_d;
            fc0_q      <= fc0_d;
            fc1_q      <= fc1_d;
            tc_q       <= tc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wd_d       = wd_q;
        tx_we_d    = 1'b0;
        tx_start_d = 1'b0;
        tx_end_d   = 1'b0;
        tx_data_d  = '0;
        fc0_d      = fc0_q;
        fc1_d      = fc1_q;
        tc_d       = tc_q;

        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_oh[1];
                    wd_d    = 16'd0;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (sel_start) begin
                    tx_start_d = 1'b1;
                    tx_we_d    = sel_we;
                    tx_data_d  = sel_data;
                    state_d    = ST_XFER;
                end else if (!sel_req) begin
                    // Requester withdrew: give the port back without counting a timeout.
                    gnt_d   = 2'b00;
                    state_d = ST_RELEASE;
                end else begin
                    wd_d = wd_q + 16'd1;
                    if (wd_d == START_TIMEOUT) begin
                        gnt_d   = 2'b00;
                        state_d = ST_RELEASE;
                        if (tc_q != 8'hFF) tc_d = tc_q + 8'd1;
                    end
                end
            end

            ST_XFER: begin
                tx_we_d    = sel_we;
                tx_start_d = sel_start;
                tx_end_d   = sel_end;
                tx_data_d  = sel_data;
                if (sel_end) begin
                    gnt_d   = 2'b00;
                    state_d = ST_RELEASE;
                    if (owner_q) fc1_d = fc1_q + 16'd1;
                    else         fc0_d = fc0_q + 16'd1;
                end
            end

            ST_RELEASE: begin
                gnt_d   = 2'b00;
                last_d  = owner_q;
                state_d = ST_IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign GNT0        = gnt_q[0];
    assign GNT1        = gnt_q[1];
    assign READY0      = gnt_q[0] & TX_READY;
    assign READY1      = gnt_q[1] & TX_READY;
    assign FULL0       = gnt_q[0] ? TX_FULL : 1'b1;
    assign FULL1       = gnt_q[1] ? TX_FULL : 1'b1;
    assign SPACE0      = gnt_q[0] ? TX_SPACE : '0;
    assign SPACE1      = gnt_q[1] ? TX_SPACE : '0;
    assign TX_WE       = tx_we_q;
    assign TX_START    = tx_start_q;
    assign TX_END      = tx_end_q;
    assign TX_DATA     = tx_data_q;
    assign FRAME_CNT0  = fc0_q;
    assign FRAME_CNT1  = fc1_q;
    assign TIMEOUT_CNT = tc_q;
    assign ARB_BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aq_gemac_tx_arb.sv
// tb/tb_aq_gemac_tx_arb.sv - scoreboard bench for aq_gemac_tx_arb
module tb_aq_gemac_tx_arb;

    logic        sys_clk;
    logic        RST_N;
    logic        req0, req1, en_rr, en_pr;
    logic        we0, start0, end0, we1, start1, end1;
    logic [31:0] data0, data1;
    logic        tx_ready, tx_full;
    logic [9:0]  tx_space;

    logic        rr_gnt0, rr_gnt1, rr_ready0, rr_ready1, rr_full0, rr_full1;
    logic [9:0]  rr_space0, rr_space1;
    logic        rr_we, rr_start, rr_end, rr_busy;
    logic [31:0] rr_data;
    logic [15:0] rr_fc0, rr_fc1;
    logic [7:0]  rr_tc;

    logic        pr_gnt0, pr_gnt1, pr_ready0, pr_ready1, pr_full0, pr_full1;
    logic [9:0]  pr_space0, pr_space1;
    logic        pr_we, pr_start, pr_end, pr_busy;
    logic [31:0] pr_data;
    logic [15:0] pr_fc0, pr_fc1;
    logic [7:0]  pr_tc;

    logic        g0, g1, mon_we, mon_start, mon_end;
    logic [31:0] mon_data;

    int n_chk  = 0;
    int n_fail = 0;
    logic pr_g1_seen = 1'b0;

    typedef struct packed {
        logic        st;
        logic        en;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    aq_gemac_tx_arb #(.PRIO_MODE(0)) u_rr (
        .RST_N(RST_N), .sys_clk(sys_clk),
        .REQ0(req0 & en_rr), .REQ1(req1 & en_rr), .GNT0(rr_gnt0), .GNT1(rr_gnt1),
        .WE0(we0), .START0(start0), .END0(end0), .DATA0(data0),
        .WE1(we1), .START1(start1), .END1(end1), .DATA1(data1),
        .READY0(rr_ready0), .READY1(rr_ready1), .FULL0(rr_full0), .FULL1(rr_full1),
        .SPACE0(rr_space0), .SPACE1(rr_space1),
        .TX_WE(rr_we), .TX_START(rr_start), .TX_END(rr_end), .TX_DATA(rr_data),
        .TX_READY(tx_ready), .TX_FULL(tx_full), .TX_SPACE(tx_space),
        .FRAME_CNT0(rr_fc0), .FRAME_CNT1(rr_fc1), .TIMEOUT_CNT(rr_tc), .ARB_BUSY(rr_busy)
    );

    aq_gemac_tx_arb #(.PRIO_MODE(1)) u_pr (
        .RST_N(RST_N), .sys_clk(sys_clk),
        .REQ0(req0 & en_pr), .REQ1(req1 & en_pr), .GNT0(pr_gnt0), .GNT1(pr_gnt1),
        .WE0(we0), .START0(start0), .END0(end0), .DATA0(data0),
        .WE1(we1), .START1(start1), .END1(end1), .DATA1(data1),
        .READY0(pr_ready0), .READY1(pr_ready1), .FULL0(pr_full0), .FULL1(pr_full1),
        .SPACE0(pr_space0), .SPACE1(pr_space1),
        .TX_WE(pr_we), .TX_START(pr_start), .TX_END(pr_end), .TX_DATA(pr_data),
        .TX_READY(tx_ready), .TX_FULL(tx_full), .TX_SPACE(tx_space),
        .FRAME_CNT0(pr_fc0), .FRAME_CNT1(pr_fc1), .TIMEOUT_CNT(pr_tc), .ARB_BUSY(pr_busy)
    );

    assign g0        = en_pr ? pr_gnt0  : rr_gnt0;
    assign g1        = en_pr ? pr_gnt1  : rr_gnt1;
    assign mon_we    = en_pr ? pr_we    : rr_we;
    assign mon_start = en_pr ? pr_start : rr_start;
    assign mon_end   = en_pr ? pr_end   : rr_end;
    assign mon_data  = en_pr ? pr_data  : rr_data;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every MAC write must match the next expected word.
    always @(negedge sys_clk) begin
        exp_t e;
        if (pr_gnt1) pr_g1_seen = 1'b1;
        if (mon_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL tx_unexpected: TX_WE=1 data=0x%0h, required no write at %0t", mon_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data",  mon_data,  e.d);
                chk("tx_start", mon_start, e.st);
                chk("tx_end",   mon_end,   e.en);
            end
        end
    end

    task automatic clear_strobes();
        we0 = 0; start0 = 0; end0 = 0; data0 = '0;
        we1 = 0; start1 = 0; end1 = 0; data1 = '0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        req0 = 0; req1 = 0;
        clear_strobes();
        repeat (2) @(posedge sys_clk);
        #1 RST_N = 1'b1;
    endtask

    task automatic drive(input int idx, input logic we, input logic st, input logic en,
                         input logic [31:0] d);
        if (idx == 0) begin
            we0 = we; start0 = st; end0 = en; data0 = d;
        end else begin
            we1 = we; start1 = st; end1 = en; data1 = d;
        end
    endtask

    task automatic wait_any_gnt(output int who, input int budget);
        who = -1;
        for (int c = 0; c < budget; c++) begin
            @(posedge sys_clk); #1;
            if (g0 | g1) begin
                who = g0 ? 0 : 1;
                break;
            end
        end
    endtask

    // Grantee sends n words (START on first, END on last); the other requester
    // optionally drives garbage strobes that must never reach the MAC.
    task automatic send_frame(input int idx, input int n, input logic [31:0] base, input bit junk);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(idx, 1'b1, i == 0, i == n - 1, base + i);
            if (junk) drive(1 - idx, 1'b1, i == 0, i == n - 1, 32'hBAD0_0000 + i);
            e.st = (i == 0);
            e.en = (i == n - 1);
            e.d  = base + i;
            exp_q.push_back(e);
            @(posedge sys_clk); #1;
            if (i == 0) begin
                chk("tx_latency_start", mon_start, 1);
                chk("tx_latency_data",  mon_data,  base);
            end
        end
        chk("gnt_drop_after_end", idx == 0 ? g0 : g1, 0);
        clear_strobes();
    endtask

    initial begin
        int who;
        int k;
        int seen;
        en_rr = 1; en_pr = 0;
        tx_ready = 1; tx_full = 0; tx_space = 10'd512;
        RST_N = 0; req0 = 0; req1 = 0;
        clear_strobes();
        repeat (2) @(posedge sys_clk); #1;
        chk("rst_gnt",   {rr_gnt1, rr_gnt0}, 0);
        chk("rst_tx",    {rr_we, rr_start, rr_end}, 0);
        chk("rst_full",  {rr_full1, rr_full0}, 2'b11);
        chk("rst_cnt",   {rr_fc1, rr_fc0}, 0);
        chk("rst_tc",    rr_tc, 0);
        chk("rst_busy",  rr_busy, 0);
        RST_N = 1;
        @(posedge sys_clk); #1;

        // Single frame from requester 1.
        req1 = 1;
        @(posedge sys_clk); #1;
        chk("t1_gnt1_rise", {rr_gnt1, rr_gnt0}, 2'b10);
        chk("t1_space_fwd", {rr_space1, rr_space0}, {10'd512, 10'd0});
        chk("t1_full_fwd",  {rr_full1, rr_full0}, 2'b01);
        send_frame(1, 6, 32'h1000_0000, 1);
        req1 = 0;
        repeat (2) @(posedge sys_clk); #1;
        chk("t1_fc1", rr_fc1, 1);
        chk("t1_fc0", rr_fc0, 0);

        // Round-robin contention.
        do_reset();
        req0 = 1; req1 = 1;
        for (int f = 0; f < 4; f++) begin
            wait_any_gnt(who, 10);
            chk("rr_order", who, f % 2);
            send_frame(who < 0 ? 0 : who, 3, 32'h2000_0000 + f * 16, 1);
        end
        req0 = 0; req1 = 0;
        repeat (3) @(posedge sys_clk); #1;
        chk("rr_fc0", rr_fc0, 2);
        chk("rr_fc1", rr_fc1, 2);

        // Space gate at the MIN_SPACE boundary.
        do_reset();
        tx_space = 10'd399;
        req0 = 1;
        seen = 0;
        repeat (6) begin
            @(posedge sys_clk); #1;
            if (rr_gnt0 | rr_gnt1) seen++;
        end
        chk("space_399_blocked", seen, 0);
        tx_space = 10'd400;
        @(posedge sys_clk); #1;
        chk("space_400_gnt0", {rr_gnt1, rr_gnt0}, 2'b01);
        req0 = 0;
        repeat (3) @(posedge sys_clk); #1;
        chk("withdraw_no_timeout", rr_tc, 0);
        chk("withdraw_idle", {rr_busy, rr_gnt0}, 0);

        // Start-of-frame watchdog.
        do_reset();
        tx_space = 10'd512;
        req0 = 1;
        wait_any_gnt(who, 10);
        chk("wd_first_gnt", who, 0);
        req1 = 1;
        k = 0;
        while (rr_gnt0 && k < 1100) begin
            @(posedge sys_clk); #1;
            k++;
        end
        chk("wd_cycles", k, 1024);
        chk("wd_timeout_cnt", rr_tc, 1);
        wait_any_gnt(who, 10);
        chk("wd_next_gnt", who, 1);
        req0 = 0;
        send_frame(1, 2, 32'h3000_0000, 0);
        req1 = 0;
        repeat (2) @(posedge sys_clk); #1;
        chk("wd_fc1", rr_fc1, 1);

        // Reset in the middle of a transfer.
        do_reset();
        req0 = 1;
        wait_any_gnt(who, 10);
        chk("mid_gnt", who, 0);
        drive(0, 1, 1, 0, 32'h4000_0000);
        exp_q.push_back('{st: 1'b1, en: 1'b0, d: 32'h4000_0000});
        @(posedge sys_clk); #1;
        drive(0, 1, 0, 0, 32'h4000_0001);
        exp_q.push_back('{st: 1'b0, en: 1'b0, d: 32'h4000_0001});
        @(posedge sys_clk); #1;
        @(negedge sys_clk); #1;
        RST_N = 0;
        #1;
        chk("mid_rst_we",   rr_we, 0);
        chk("mid_rst_gnt0", rr_gnt0, 0);
        clear_strobes();
        req0 = 0;
        repeat (2) @(posedge sys_clk); #1;
        RST_N = 1;
        chk("mid_fc0", rr_fc0, 0);
        chk("mid_busy", rr_busy, 0);
        req0 = 1; req1 = 1;
        wait_any_gnt(who, 10);
        chk("mid_first_gnt", who, 0);
        send_frame(0, 2, 32'h5000_0000, 1);
        req0 = 0; req1 = 0;
        repeat (3) @(posedge sys_clk); #1;

        // Fixed priority instance.
        RST_N = 0;
        en_rr = 0; en_pr = 1;
        repeat (2) @(posedge sys_clk); #1;
        RST_N = 1;
        req0 = 1; req1 = 1;
        for (int f = 0; f < 3; f++) begin
            wait_any_gnt(who, 10);
            chk("prio_gnt", who, 0);
            send_frame(0, 2, 32'h6000_0000 + f * 16, 1);
        end
        req0 = 0; req1 = 0;
        repeat (3) @(posedge sys_clk); #1;
        chk("prio_fc0", pr_fc0, 3);
        chk("prio_fc1", pr_fc1, 0);
        chk("prio_gnt1_never", pr_g1_seen, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_gemac_tx_arb.md
Name: aq_gemac_tx_arb

Overview:
- Frame-atomic arbiter that shares the single MAC TX buffer write port between two frame producers:
  - requester 0: L3 controller (ARP/ICMP replies)
  - requester 1: UDP controller (user datagrams)
- Grants one requester per frame using round-robin or fixed priority, then muxes its WE/START/END/DATA onto the MAC TX buffer through a one-cycle register stage.
- Enforces a start-of-frame watchdog and keeps per-requester frame counters.
- Sits between the L3/UDP controllers and aq_gemac, in the sys_clk domain.

Parameters:
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, requester 0 wins.
- MIN_SPACE, 10'd400, minimum free MAC TX buffer words (TX_SPACE) required before a grant is issued.
- START_TIMEOUT, 16'd1024, cycles a grantee may hold a grant without pulsing START.

Ports:
- RST_N  in  1  asynchronous reset, active-low
- sys_clk  in  1  system clock
- REQ0, REQ1  in  1 each  level, frame pending at requester n
- GNT0, GNT1  out  1 each  grant to requester n
- WE0, START0, END0  in  1 each  requester 0 write strobes
- DATA0  in  32  requester 0 write data
- WE1, START1, END1  in  1 each  requester 1 write strobes
- DATA1  in  32  requester 1 write data
- READY0, READY1  out  1 each  MAC READY, forwarded to the grantee only, else 0
- FULL0, FULL1  out  1 each  MAC FULL, forwarded to the grantee only, else 1
- SPACE0, SPACE1  out  10 each  MAC SPACE, forwarded to the grantee only, else 0
- TX_WE, TX_START, TX_END  out  1 each  to MAC TX buffer
- TX_DATA  out  32  to MAC TX buffer
- TX_READY  in  1  MAC buffer ready
- TX_FULL  in  1  MAC buffer full
- TX_SPACE  in  10  MAC buffer free words
- FRAME_CNT0, FRAME_CNT1  out  16 each  completed frames per requester, wrapping
- TIMEOUT_CNT  out  8  watchdog revocations, saturating at 255
- ARB_BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - all outputs 0, except FULL0/FULL1 = 1
  - state IDLE
  - round-robin pointer `last` = 1, so requester 0 wins the first tie
- FSM states: IDLE, GRANT, XFER, RELEASE.
- IDLE:
  - Eligible when (REQ0|REQ1) && TX_READY && !TX_FULL && TX_SPACE >= MIN_SPACE.
  - Winner selection:
    - PRIO_MODE=1: REQ0 wins.
    - PRIO_MODE=0: the requester other than `last` wins if it requests, else the single requester.
  - Set GNTn next cycle; go to GRANT; clear watchdog counter.
- GRANT:
  - Grantee START (with or without WE) is registered to TX_START and TX_WE/TX_DATA; go to XFER.
  - Watchdog counter increments each cycle. When it reaches START_TIMEOUT: drop GNT, TIMEOUT_CNT++ (saturating), go to RELEASE. No strobe reaches the MAC.
  - REQ deasserted before START: same as timeout path but TIMEOUT_CNT is not incremented.
- XFER:
  - Grantee WE/END/DATA are registered to the TX_* outputs with latency exactly 1 cycle.
  - Non-grantee strobes are ignored in every state.
  - END from the grantee: END is forwarded; FRAME_CNTn++ (wrapping 0xFFFF -> 0); go to RELEASE.
  - START from the grantee while in XFER is forwarded unchanged; the arbiter does not police frame contents.
- RELEASE (1 cycle):
  - GNT0 = GNT1 = 0; TX_* strobes = 0.
  - `last` := served index.
  - Go to IDLE, so there is a minimum 1 idle cycle between frames.
- GNT de-assertion: GNT stays high through the END cycle and drops the cycle after END is sampled.
- Simultaneous REQ0 & REQ1 in round-robin mode: grants alternate 0,1,0,1 while both stay asserted.
- TX_FULL during XFER: not acted on by the arbiter. The grantee sees FULLn and must throttle WE itself.
- Reset mid-frame: all strobes drop asynchronously; the MAC is responsible for discarding the partial frame.

Decomposition:
- Shared package aq_gemac_pkg holds:
  - FSM state encoding (2 bits)
  - TX buffer width constants (DATA 32, SPACE 10)
  - default MIN_SPACE
- One natural sub-module: aq_gemac_tx_arb_pick, the combinational winner select taking req[1:0], last and PRIO_MODE and producing a one-hot grant. Everything else stays in the top FSM.

Test Plan:
- Single frame: REQ1 high, TX_SPACE=512 -> GNT1 rises 1 cycle later. Grantee sends START+WE, 4 WE, END -> TX_* sequence appears 1 cycle delayed with identical DATA; FRAME_CNT1=1; GNT1 low the cycle after END.
- Round-robin contention: REQ0 and REQ1 held high for 4 frames each of 3 words -> grant order 0,1,0,1; FRAME_CNT0=FRAME_CNT1=2 after the first 4 frames.
- Fixed priority: PRIO_MODE=1, both requesting continuously -> only GNT0 ever asserted; FRAME_CNT1 stays 0.
- Space gate: TX_SPACE=399 with REQ0 high -> no grant. Raise TX_SPACE to 400 -> GNT0 within 1 cycle.
- Watchdog: GNT0 issued, no START for 1024 cycles -> GNT0 drops; TIMEOUT_CNT=1; no TX_WE pulse seen; a pending REQ1 is granted next.
- Reset mid-XFER: drop RST_N after 2 data words -> TX_WE/GNT0 go 0 immediately. After release, FRAME_CNT0=0, state IDLE, first grant goes to requester 0.
